// File: rtl/jam1_alu_pkg.sv
// Shared definitions for the JAM-1 ALU flag logic.
//   carry_mode codes : carry-in selection requested of the adder
//   flag_op codes    : explicit flag manipulation ops
//   F_* indices      : bit positions inside a {V,S,Z,C} flag image
package jam1_alu_pkg;

  localparam logic [1:0] CM_ZERO = 2'b00;
  localparam logic [1:0] CM_FLAG = 2'b01;
  localparam logic [1:0] CM_ONE  = 2'b10;

  localparam logic [1:0] FOP_NONE = 2'b00;
  localparam logic [1:0] FOP_CLC  = 2'b01;
  localparam logic [1:0] FOP_SEC  = 2'b10;
  localparam logic [1:0] FOP_LOAD = 2'b11;

  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_S = 2;
  localparam int F_V = 3;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational C/Z/S/V derivation from an adder result.
// Ports:
//   lhs, rhs   : adder operands (rhs already inverted for subtract)
//   sum        : adder result
//   carry_out  : adder carry out
//   flags      : derived {V,S,Z,C}
module alu_flag_calc
  import jam1_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry_out,
  output logic [3:0]       flags
);

  always_comb begin
    flags      = 4'b0000;
    flags[F_C] = carry_out;
    flags[F_Z] = (sum == '0);
    flags[F_S] = sum[WIDTH-1];
    // Signed overflow: operands agree in sign but the result does not.
    flags[F_V] = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
  end

endmodule

// File: rtl/alu_flags.sv
// JAM-1 ALU flags unit. Captures a candidate flag image into a pending stage,
// commits it to flags_q on the following edge, and forwards the pending image
// so a carry-chained op right behind a flag writer sees the new carry.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   stall                 : holds pending stage and committed flags
//   flush                 : drops this cycle's capture
//   flags_we, flag_op     : arithmetic flag write / CLC, SEC, LOAD
//   flags_in              : {V,S,Z,C} image for LOAD
//   carry_mode            : carry-in request, echoed as CarrySelectB/A
//   LHS, RHS, AdderOut, CarryOut : adder interface
//   CarrySelectA/B        : carry-select encode to the adder
//   CarryFlag             : forwarded carry flag
//   flags_q               : committed {V,S,Z,C}
module alu_flags
  import jam1_alu_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             flags_we,
  input  logic [1:0]       flag_op,
  input  logic [3:0]       flags_in,
  input  logic [1:0]       carry_mode,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  input  logic [WIDTH-1:0] AdderOut,
  input  logic             CarryOut,
  output logic             CarrySelectA,
  output logic             CarrySelectB,
  output logic             CarryFlag,
  output logic [3:0]       flags_q
);

  logic [3:0] derived;
  logic [3:0] fwd;
  logic [3:0] cand;
  logic       capture;

  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_flags_q, pend_flags_d;
  logic [3:0] flags_d;

  alu_flag_calc #(.WIDTH(WIDTH)) u_calc (
    .lhs       (LHS),
    .rhs       (RHS),
    .sum       (AdderOut),
    .carry_out (CarryOut),
    .flags     (derived)
  );

  // The encode is a straight echo of carry_mode; the adder decodes 11 as 0.
  assign CarrySelectA = carry_mode[0];
  assign CarrySelectB = carry_mode[1];

  assign fwd       = pend_valid_q ? pend_flags_q : flags_q;
  assign CarryFlag = fwd[F_C];
  assign capture   = flags_we || (flag_op != FOP_NONE);

  always_comb begin
    cand = derived;
    case (flag_op)
      FOP_CLC:  cand = {fwd[3:1], 1'b0};
      FOP_SEC:  cand = {fwd[3:1], 1'b1};
      FOP_LOAD: cand = flags_in;
      default:  cand = derived;
    endcase
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_flags_d = pend_flags_q;
    flags_d      = flags_q;
    if (!stall) begin
      if (pend_valid_q) flags_d = pend_flags_q;
      pend_valid_d = capture && !flush;
      pend_flags_d = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= FLAG_RST;
      pend_valid_q <= 1'b0;
      pend_flags_q <= 4'b0000;
    end else begin
      flags_q      <= flags_d;
      pend_valid_q <= pend_valid_d;
      pend_flags_q <= pend_flags_d;
    end
  end

endmodule

// File: doc/alu_flags.md
Name: alu_flags

Overview:
- Flags unit for the JAM-1 ALU; it sits at the far end of the adder's carry interface.
- It consumes the adder's result and CarryOut, derives the C/Z/S/V flags, and passes them through one pending stage into the committed flags register.
- It returns CarryFlag and the CarrySelectA/B encoding to the adder, closing the ADC/SBC carry loop.
- Pending-stage forwarding lets back-to-back carry-chained instructions run without a bubble.

Parameters:
- WIDTH, 8, ALU datapath width; the sign bit is WIDTH-1.
- FLAG_RST, 4'b0000, committed flags {V,S,Z,C} after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; blocks both capture and commit.
- flush  in  1  squashes this cycle's capture only.
- flags_we  in  1  current ALU op writes the arithmetic flags.
- flag_op  in  2  00 none, 01 CLC, 10 SEC, 11 LOAD from flags_in.
- flags_in  in  4  {V,S,Z,C} image for LOAD (flag pop).
- carry_mode  in  2  00 carry-in 0, 01 carry-in = CarryFlag, 10 carry-in 1, 11 carry-in 0.
- LHS  in  WIDTH  adder left operand.
- RHS  in  WIDTH  adder right operand, after any inversion.
- AdderOut  in  WIDTH  adder sum.
- CarryOut  in  1  adder carry out.
- CarrySelectA  out  1  carry-select encode to the adder.
- CarrySelectB  out  1  carry-select encode to the adder.
- CarryFlag  out  1  forwarded carry flag.
- flags_q  out  4  committed {V,S,Z,C}.

Behaviour:
- Reset (async, rst_n=0):
  - flags_q=FLAG_RST; pend_valid=0; pend_flags=0.
  - CarryFlag=FLAG_RST[0].
  - Reset mid-operation discards any pending write.
- Carry-select encode (combinational, from carry_mode):
  - 00 -> {B,A}=00; 01 -> 01; 10 -> 10; 11 -> 11.
  - The adder selects carry-in: {B,A}=00 -> 0, 01 -> CarryFlag, 10 -> 1, 11 -> 0.
- Flag derivation (combinational, capture stage):
  - C = CarryOut.
  - Z = (AdderOut==0).
  - S = AdderOut[WIDTH-1].
  - V = (LHS[msb]==RHS[msb]) & (AdderOut[msb]!=LHS[msb]).
- Capture candidate priority: flag_op!=00 beats flags_we.
  - CLC: C cleared, other flags taken from the forwarded view.
  - SEC: C set, other flags taken from the forwarded view.
  - LOAD: flags_in.
  - flags_we only: derived flags.
- Forwarded view = pend_valid ? pend_flags : flags_q.
- Clock edge, stall=0:
  - Commit: if pend_valid then flags_q <= pend_flags.
  - Capture: pend_valid <= (flags_we | flag_op!=00) & ~flush; pend_flags <= candidate.
- Clock edge, stall=1: pend_valid, pend_flags and flags_q all hold.
- flush with stall=0: no new capture; an already-pending write still commits. flush has no effect while stall=1.
- CarryFlag = forwarded view C bit (combinational). The instruction right after a flag writer sees the new carry with zero bubble.
- Latency: flags_q updates 2 edges after the writing op is presented; CarryFlag updates after 1 edge.
- Back-to-back writers: pending stage commits and recaptures on the same edge, so no write is lost.
- Combinational paths: CarryFlag depends on registers only. AdderOut -> flags has no path to CarrySelect*, so there is no combinational loop with the adder.

Decomposition:
- Shared package jam1_alu_pkg holds:
  - carry_mode codes: CM_ZERO, CM_FLAG, CM_ONE.
  - flag_op codes: FOP_NONE, FOP_CLC, FOP_SEC, FOP_LOAD.
  - flag bit indices: F_C=0, F_Z=1, F_S=2, F_V=3.
- One sub-module, alu_flag_calc: combinational C/Z/S/V derivation. It is reused by the future logic unit.

Test Plan:
- Reset: assert rst_n=0 mid-write -> flags_q=0000, CarryFlag=0 immediately, no commit after release.
- ADD then ADC back-to-back:
  - Cycle 0: LHS=FF, RHS=01, sum 00, CarryOut=1.
  - Cycle 1: CarryFlag=1; carry_mode=01 gives {B,A}=01.
  - Cycle 2: flags_q=0011 (Z,C).
- Overflow: LHS=7F, RHS=01, sum 80, CarryOut=0 -> two edges later flags_q={V=1,S=1,Z=0,C=0}=1100.
- Simultaneous ops: flags_we=1 with flag_op=SEC and a sum producing C=0 -> C=1 captured, other flags from the forwarded view. Then LOAD flags_in=1010 -> flags_q=1010.
- Stall/flush:
  - With a write pending, stall=1 for 3 cycles -> flags_q unchanged, CarryFlag holds the pending C.
  - flush=1 on a new writer -> older write commits, new one dropped.
- carry_mode sweep 00/01/10/11 -> {B,A}=00/01/10/11; the adder sees carry-in 0/C/1/0.
